tanh_step_controller: RTL and testbench

- Iteration sequencer that sits directly upstream of state_selector and feeds it.
- Produces start_req, which drives state_selector.mux1, and done_req, which drives state_selector.mux2.
- Reads back the registered busy bit (state_selector.state) to run a fixed-length iteration loop for the tanh datapath.
- Owns the input/output valid-ready handshakes, the datapath load/step strobes and the iteration index used for coefficient lookup.

---
 rtl/tanh_step_controller.sv | 74 +++++++
 tb/tb_tanh_step_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_step_controller.sv
// rtl/tanh_step_controller.sv - iteration sequencer feeding state_selector for the tanh datapath
// Drives start/done requests to the selector and paces a fixed-length step loop.
module tanh_step_controller #(
    parameter int ITER_COUNT = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             state,
    output logic             start_req,
    output logic             done_req,
    output logic             load_x,
    output logic             step_en,
    output logic [CNT_W-1:0] iter_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    // One extra bit so ITER_COUNT == 2**CNT_W still compares correctly.
    localparam logic [CNT_W:0] ITER_LIM  = (CNT_W+1)'(ITER_COUNT);
    localparam logic [CNT_W:0] ITER_LAST = (CNT_W+1)'(ITER_COUNT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_ext;
    logic             in_range;

    assign cnt_ext  = {1'b0, cnt};
    assign in_range = (cnt_ext < ITER_LIM);
    assign iter_idx = cnt;

    always_comb begin
        in_ready  = 1'b0;
        start_req = 1'b0;
        load_x    = 1'b0;
        step_en   = 1'b0;
        done_req  = 1'b0;
        if (!reset_b) begin
            in_ready  = !state && !out_valid;
            start_req = in_valid && in_ready;
            load_x    = start_req;
            step_en   = state && in_range;
            done_req  = step_en && (cnt_ext == ITER_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset_b) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (start_req || done_req) begin
                cnt <= '0;
            end else if (step_en) begin
                cnt <= cnt + 1'b1;
            end

            if (done_req) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Busy with an exhausted count or with a result still pending means the selector is out of step.
            if (state && (!in_range || out_valid)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tanh_step_controller.sv
// tb/tb_tanh_step_controller.sv - self-checking bench for tanh_step_controller
// Timeline reference model plus a behavioural state_selector stand-in.
module tb_tanh_step_controller;

    localparam int ITER  = 8;
    localparam int CW    = 4;
    localparam int ITER2 = 2;
    localparam int CW2   = 1;

    logic          clock;
    logic          reset_b;
    logic          in_valid, in_ready, state, start_req, done_req, load_x, step_en;
    logic [CW-1:0] iter_idx;
    logic          out_valid, out_ready, err;

    logic           in_valid2, in_ready2, state2, start_req2, done_req2, load_x2, step_en2;
    logic [CW2-1:0] iter_idx2;
    logic           out_valid2, out_ready2, err2;

    logic sel, sel2, force_en;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Timeline model: busy/phase since accept, and pending result.
    bit m_busy = 0;
    bit m_pend = 0;
    int m_t    = 0;

    logic s_in_ready, s_start, s_step, s_out_valid;
    logic [CW-1:0] s_iter_idx;

    tanh_step_controller #(.ITER_COUNT(ITER), .CNT_W(CW)) dut (
        .clock(clock), .reset_b(reset_b), .in_valid(in_valid), .in_ready(in_ready),
        .state(state), .start_req(start_req), .done_req(done_req), .load_x(load_x),
        .step_en(step_en), .iter_idx(iter_idx), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    tanh_step_controller #(.ITER_COUNT(ITER2), .CNT_W(CW2)) dut2 (
        .clock(clock), .reset_b(reset_b), .in_valid(in_valid2), .in_ready(in_ready2),
        .state(state2), .start_req(start_req2), .done_req(done_req2), .load_x(load_x2),
        .step_en(step_en2), .iter_idx(iter_idx2), .out_valid(out_valid2),
        .out_ready(out_ready2), .err(err2)
    );

    always @(posedge clock) begin
        if (reset_b) sel <= 1'b0;
        else if (start_req) sel <= 1'b1;
        else if (done_req) sel <= 1'b0;
    end
    always @(posedge clock) begin
        if (reset_b) sel2 <= 1'b0;
        else if (start_req2) sel2 <= 1'b1;
        else if (done_req2) sel2 <= 1'b0;
    end
    assign state  = force_en ? 1'b1 : sel;
    assign state2 = sel2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
        $fatal(1);
    end

    // One clock cycle of dut with model comparison; sampled values kept in s_*.
    task automatic cyc(input logic iv, input logic ordy, input logic rst);
        logic e_ir, e_st, e_step, e_done;
        int   e_idx;
        in_valid  = iv;
        out_ready = ordy;
        reset_b   = rst;
        @(negedge clock);
        if (rst) begin
            e_ir = 0; e_st = 0; e_step = 0; e_done = 0;
        end else begin
            e_ir   = !m_busy && !m_pend;
            e_st   = iv && e_ir;
            e_step = m_busy;
            e_done = m_busy && (m_t == ITER);
        end
        e_idx = m_t - 1;
        checks++;
        if (in_ready !== e_ir) begin errors++; $display("FAIL in_ready cyc %0d: got %b want %b", cyc_n, in_ready, e_ir); end
        checks++;
        if (start_req !== e_st || load_x !== e_st) begin errors++; $display("FAIL start_req/load_x cyc %0d: got %b/%b want %b", cyc_n, start_req, load_x, e_st); end
        checks++;
        if (step_en !== e_step) begin errors++; $display("FAIL step_en cyc %0d: got %b want %b", cyc_n, step_en, e_step); end
        checks++;
        if (done_req !== e_done) begin errors++; $display("FAIL done_req cyc %0d: got %b want %b", cyc_n, done_req, e_done); end
        checks++;
        if (out_valid !== m_pend) begin errors++; $display("FAIL out_valid cyc %0d: got %b want %b", cyc_n, out_valid, m_pend); end
        checks++;
        if (state !== m_busy) begin errors++; $display("FAIL state cyc %0d: got %b want %b", cyc_n, state, m_busy); end
        if (e_step) begin
            checks++;
            if (iter_idx !== CW'(e_idx)) begin errors++; $display("FAIL iter_idx cyc %0d: got %0d want %0d", cyc_n, iter_idx, e_idx); end
        end
        if (!rst) begin
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL err cyc %0d: got %b want 0", cyc_n, err); end
        end
        s_in_ready = in_ready; s_start = start_req; s_step = step_en;
        s_out_valid = out_valid; s_iter_idx = iter_idx;
        if (rst) begin
            m_busy = 0; m_pend = 0; m_t = 0;
        end else begin
            if (m_pend && ordy) m_pend = 0;
            if (e_st) begin
                m_busy = 1; m_t = 1;
            end else if (m_busy) begin
                if (m_t == ITER) begin m_busy = 0; m_pend = 1; end
                else m_t++;
            end
        end
        @(posedge clock);
        #1;
        cyc_n++;
    endtask

    task automatic test_reset();
        cyc(1, 1, 1);
        cyc(1, 1, 1);
        @(negedge clock);
        checks++;
        if (iter_idx !== '0 || err !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_regs: idx %0d err %b ov %b want 0 0 0", iter_idx, err, out_valid);
        end
        @(posedge clock); #1;
        reset_b = 0;
        cyc(0, 1, 0);
    endtask

    task automatic test_single();
        cyc(1, 1, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0);
    endtask

    task automatic test_backpressure();
        int held = 0;
        cyc(1, 0, 0);
        for (int i = 1; i <= ITER; i++) cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0);
            if (s_out_valid && !s_in_ready && !s_start) held++;
        end
        checks++;
        if (held != 5) begin errors++; $display("FAIL bp_hold: held %0d cycles want 5", held); end
        cyc(1, 1, 0);
        checks++;
        if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_release: ov %b ir %b want 1 0", s_out_valid, s_in_ready); end
        cyc(1, 1, 0);
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_start !== 1'b1) begin
            errors++; $display("FAIL bp_next: ov %b ir %b start %b want 0 1 1", s_out_valid, s_in_ready, s_start);
        end
        for (int i = 0; i < 12; i++) cyc(0, 1, 0);
    endtask

    task automatic test_back_to_back();
        int starts[$];
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0);
            if (s_start) starts.push_back(cyc_n);
        end
        checks++;
        if (starts.size() < 3) begin errors++; $display("FAIL b2b_count: %0d accepts want >=3", starts.size()); end
        for (int i = 1; i < starts.size(); i++) begin
            checks++;
            if (starts[i] - starts[i-1] != ITER + 2) begin
                errors++; $display("FAIL b2b_spacing: %0d cycles want %0d", starts[i] - starts[i-1], ITER + 2);
            end
        end
        for (int i = 0; i < 12; i++) cyc(0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) cyc(1'(($urandom % 3) != 0), 1'(($urandom % 2) == 1), 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0);
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        cyc(1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        checks++;
        if (s_iter_idx !== '0 || s_step !== 1'b0 || s_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid: idx %0d step %b ov %b want 0 0 0", s_iter_idx, s_step, s_out_valid);
        end
        for (int i = 0; i < 15; i++) begin
            cyc(0, 1, 0);
            if (s_out_valid) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL reset_mid_spurious: %0d out_valid cycles want 0", spurious); end
    endtask

    task automatic test_error();
        in_valid  = 1;
        out_ready = 0;
        force_en  = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (c < ITER) begin
                checks++;
                if (step_en !== 1'b1 || iter_idx !== CW'(c)) begin
                    errors++; $display("FAIL err_step c%0d: step %b idx %0d want 1 %0d", c, step_en, iter_idx, c);
                end
            end
            checks++;
            if (done_req !== (c == ITER - 1)) begin errors++; $display("FAIL err_done c%0d: got %b", c, done_req); end
            checks++;
            if (start_req !== 1'b0) begin errors++; $display("FAIL err_nostart c%0d: got %b want 0", c, start_req); end
            checks++;
            if (err !== (c >= ITER + 1)) begin errors++; $display("FAIL err_flag c%0d: got %b want %b", c, err, (c >= ITER + 1)); end
            @(posedge clock); #1;
            cyc_n++;
        end
        force_en = 0;
        in_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL err_sticky c%0d: got %b want 1", c, err); end
            @(posedge clock); #1;
            cyc_n++;
        end
        m_busy = 0; m_pend = 1; m_t = 0;
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
    endtask

    task automatic test_iter2();
        out_ready2 = 0;
        in_valid2  = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (start_req2 !== (c == 0)) begin errors++; $display("FAIL i2_start c%0d: got %b", c, start_req2); end
            checks++;
            if (step_en2 !== (c >= 1 && c <= ITER2)) begin errors++; $display("FAIL i2_step c%0d: got %b", c, step_en2); end
            checks++;
            if (done_req2 !== (c == ITER2)) begin errors++; $display("FAIL i2_done c%0d: got %b", c, done_req2); end
            if (c == ITER2) begin
                checks++;
                if (iter_idx2 !== 1'b1) begin errors++; $display("FAIL i2_idx: got %0d want 1", iter_idx2); end
            end
            checks++;
            if (out_valid2 !== (c >= ITER2 + 1)) begin errors++; $display("FAIL i2_ov c%0d: got %b", c, out_valid2); end
            if (c == ITER2 + 1) begin
                checks++;
                if (state2 !== 1'b0) begin errors++; $display("FAIL i2_state: got %b want 0", state2); end
            end
            @(posedge clock); #1;
            in_valid2 = 0;
            cyc_n++;
        end
        out_ready2 = 1;
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin errors++; $display("FAIL i2_drain: ov %b ir %b want 0 1", out_valid2, in_ready2); end
        @(posedge clock); #1;
    endtask

    initial begin
        reset_b    = 1;
        in_valid   = 0;
        out_ready  = 1;
        in_valid2  = 0;
        out_ready2 = 1;
        force_en   = 0;
        @(posedge clock); #1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_iter2();
        test_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
